// File: rtl/bin2seg_seq.sv
// bin2seg_seq: sequential binary-to-BCD converter (double dabble, one bit per
// clock) that also drives one active-low seven-segment pattern per digit.
// Handshake: start is accepted while ready=1; valid pulses once when
// bcd/seg/overflow have been refreshed.
module bin2seg_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  overflow
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_bin;
    logic [SW-1:0]       r_scr;
    logic                r_ovf;
    logic                r_ready;
    logic                r_valid;
    logic [SW-1:0]       r_bcd;
    logic [7*DIGITS-1:0] r_seg;
    logic                r_overflow;

    logic [SW-1:0]       w_adj;
    logic [SW-1:0]       w_scr_shift;
    logic [WIDTH-1:0]    w_bin_shift;
    logic                w_carry;
    logic [7*DIGITS-1:0] w_seg;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // Add-3 correction on every digit >= 5, then one left shift of {scratch, bin}.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_adj[4*i +: 4] = (r_scr[4*i +: 4] >= 4'd5) ? r_scr[4*i +: 4] + 4'd3
                                                         : r_scr[4*i +: 4];
        end
        w_carry     = w_adj[SW-1];
        w_scr_shift = {w_adj[SW-2:0], r_bin[WIDTH-1]};
        w_bin_shift = {r_bin[WIDTH-2:0], 1'b0};
    end

    // Segment patterns from the finished scratch: dashes on overflow,
    // optional leading-zero blanking (digit 0 is never blanked).
    always_comb begin
        logic l_nz;
        w_seg = '1;
        l_nz  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            l_nz = l_nz | (r_scr[4*i +: 4] != 4'd0);
            if (r_ovf)
                w_seg[7*i +: 7] = 7'h3F;
            else if ((LZB != 0) && !l_nz && (i != 0))
                w_seg[7*i +: 7] = 7'h7F;
            else
                w_seg[7*i +: 7] = seg_of(r_scr[4*i +: 4]);
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, WIDTH shift cycles, one DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(WIDTH - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Conversion datapath and registered outputs; outputs only change in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bin      <= '0;
            r_scr      <= '0;
            r_ovf      <= 1'b0;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_bcd      <= '0;
            r_seg      <= '1;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_scr   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_scr <= w_scr_shift;
                    r_bin <= w_bin_shift;
                    r_ovf <= r_ovf | w_carry;
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_bcd      <= r_scr;
                    r_seg      <= w_seg;
                    r_overflow <= r_ovf;
                    r_valid    <= 1'b1;
                    r_ready    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready    = r_ready;
    assign valid    = r_valid;
    assign bcd      = r_bcd;
    assign seg      = r_seg;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2seg_seq.sv
// Bench for bin2seg_seq: a 4-digit instance and a 3-digit instance driven with
// directed vectors; expected results are queued at issue time and checked by
// per-instance monitors whenever valid is seen.
module tb_bin2seg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start3;
    logic [11:0] bin4, bin3;
    logic        ready4, valid4, ovf4;
    logic        ready3, valid3, ovf3;
    logic [15:0] bcd4;
    logic [27:0] seg4;
    logic [11:0] bcd3;
    logic [20:0] seg3;

    typedef struct {
        logic [15:0] bcd;
        logic [27:0] seg;
        logic        ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;

    bin2seg_seq #(.WIDTH(12), .DIGITS(4), .LZB(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin(bin4),
        .ready(ready4), .valid(valid4), .bcd(bcd4), .seg(seg4), .overflow(ovf4)
    );

    bin2seg_seq #(.WIDTH(12), .DIGITS(3), .LZB(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin(bin3),
        .ready(ready3), .valid(valid3), .bcd(bcd3), .seg(seg3), .overflow(ovf3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 4-digit instance.
    always @(negedge clk) begin
        if (valid4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("dut4_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_bcd", {16'd0, bcd4}, {16'd0, e.bcd});
                chk("dut4_seg", {4'd0, seg4}, {4'd0, e.seg});
                chk("dut4_ovf", {31'd0, ovf4}, {31'd0, e.ovf});
            end
        end
    end

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin
        if (valid3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("dut3_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("dut3_bcd", {20'd0, bcd3}, {20'd0, e.bcd[11:0]});
                chk("dut3_seg", {11'd0, seg3}, {11'd0, e.seg[20:0]});
                chk("dut3_ovf", {31'd0, ovf3}, {31'd0, e.ovf});
            end
        end
    end

    task automatic drive(input bit sel, input logic s, input logic [11:0] b);
        if (sel) begin start3 = s; bin3 = b; end
        else     begin start4 = s; bin4 = b; end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready3 : ready4;
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? valid3 : valid4;
    endfunction

    // Issue one conversion (called #1 after an edge with ready=1); returns
    // #1 after the edge that raised valid. Optional noise: stray start/bin
    // activity during SHIFT that must be ignored.
    task automatic convert(input bit sel, input logic [11:0] v, input logic [15:0] eb,
                           input logic [27:0] es, input logic eo, input bit noise);
        exp_t e;
        int   n;
        int   low;
        e.bcd = eb; e.seg = es; e.ovf = eo;
        chk("idle_ready", {31'd0, rdy(sel)}, 32'd1);
        if (sel) q3.push_back(e); else q4.push_back(e);
        drive(sel, 1'b1, v);
        @(posedge clk); #1;
        drive(sel, 1'b0, noise ? 12'd99 : v);
        chk("accept_ready_low", {31'd0, rdy(sel)}, 32'd0);
        low = 1;
        n   = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (vld(sel)) break;
            if (!rdy(sel)) low++;
            if (noise && n == 3) drive(sel, 1'b1, 12'd99);
            if (noise && n == 7) drive(sel, 1'b0, 12'd99);
        end
        chk("latency", n, 32'd13);
        chk("ready_low_cycles", low, 32'd13);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, ready4}, 32'd1);
        chk({tag, "_valid"}, {31'd0, valid4}, 32'd0);
        chk({tag, "_bcd"},   {16'd0, bcd4},   32'd0);
        chk({tag, "_seg"},   {4'd0, seg4},    32'h0FFF_FFFF);
        chk({tag, "_ovf"},   {31'd0, ovf4},   32'd0);
    endtask

    initial begin
        rst = 1'b1; start4 = 1'b0; start3 = 1'b0; bin4 = '0; bin3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        chk("reset3_seg", {11'd0, seg3}, 32'h001F_FFFF);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Zero: units shows 0, upper digits blanked.
        convert(0, 12'd0,    16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 0);
        @(posedge clk); #1;
        // Full-scale 12-bit input.
        convert(0, 12'd4095, 16'h4095, {7'h19, 7'h40, 7'h10, 7'h12}, 1'b0, 0);
        @(posedge clk); #1;
        // Interior zero is not blanked.
        convert(0, 12'd305,  16'h0305, {7'h7F, 7'h30, 7'h40, 7'h12}, 1'b0, 0);
        @(posedge clk); #1;
        // Stray start and bin changes mid-conversion are ignored.
        convert(0, 12'd1234, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0, 1);
        repeat (20) @(posedge clk);
        #1;
        // Back-to-back: second start issued in the valid cycle.
        convert(0, 12'd7,    16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0, 0);
        convert(0, 12'd60,   16'h0060, {7'h7F, 7'h7F, 7'h02, 7'h40}, 1'b0, 0);
        @(posedge clk); #1;

        // Reset in the middle of converting 2048: abandoned, no valid.
        drive(0, 1'b1, 12'd2048);
        @(posedge clk); #1;
        drive(0, 1'b0, 12'd2048);
        repeat (5) @(posedge clk);
        #1;
        chk("midconv_ready", {31'd0, ready4}, 32'd0);
        rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        convert(0, 12'd9,    16'h0009, {7'h7F, 7'h7F, 7'h7F, 7'h10}, 1'b0, 0);
        @(posedge clk); #1;

        // Three-digit instance: overflow and largest representable value.
        convert(1, 12'd1000, 16'h0000, {7'h00, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 0);
        @(posedge clk); #1;
        convert(1, 12'd999,  16'h0999, {7'h00, 7'h10, 7'h10, 7'h10}, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;

        chk("q4_drained", q4.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
